// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared definitions for the calculator sequencer: keypad key
//                codes, ALU operation codes, sequencer states and small key
//                decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Keypad key codes as delivered by the keypad scanner
  localparam logic [4:0] T_0    = 5'd0;
  localparam logic [4:0] T_1    = 5'd1;
  localparam logic [4:0] T_2    = 5'd2;
  localparam logic [4:0] T_3    = 5'd3;
  localparam logic [4:0] T_4    = 5'd4;
  localparam logic [4:0] T_5    = 5'd5;
  localparam logic [4:0] T_6    = 5'd6;
  localparam logic [4:0] T_7    = 5'd7;
  localparam logic [4:0] T_8    = 5'd8;
  localparam logic [4:0] T_9    = 5'd9;
  localparam logic [4:0] T_A    = 5'd10;  // SUM
  localparam logic [4:0] T_B    = 5'd11;  // SUB
  localparam logic [4:0] T_C    = 5'd12;  // MUL
  localparam logic [4:0] T_D    = 5'd13;  // backspace when enabled
  localparam logic [4:0] T_ASTE = 5'd14;  // CLEAR
  localparam logic [4:0] T_HASH = 5'd15;  // EQUALS

  // ALU operation select
  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  // Largest value representable by a two-digit operand
  localparam int         MAX_OPERAND = 99;
  localparam logic [1:0] DIGITS_MAX  = 2'd2;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_SHOW = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [4:0] k);
    return (k <= T_9);
  endfunction

  function automatic logic is_op(input logic [4:0] k);
    return (k == T_A) || (k == T_B) || (k == T_C);
  endfunction

  function automatic logic [1:0] key_to_op(input logic [4:0] k);
    logic [1:0] op;
    case (k)
      T_B:     op = OP_SUB;
      T_C:     op = OP_MUL;
      default: op = OP_SUM;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_accum.sv
`default_nettype none
// ============================================================================
//  Module      : digit_accum
//  Description : Two-digit decimal operand accumulator. Holds a 7-bit value
//                and the number of digits entered so far (0..2).
//                Priority: load > clr > push > bksp.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                clr              - zero value and count
//                load/load_val/load_cnt - overwrite value and count
//                push/digit       - append a decimal digit (ignored at 2)
//                bksp             - drop last digit (ignored at 0)
//                value, count     - current operand and digit count
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic [1:0] load_cnt,
  input  logic       push,
  input  logic [3:0] digit,
  input  logic       bksp,
  output logic [6:0] value,
  output logic [1:0] count
);
  import calc_pkg::*;

  logic [6:0] r_value;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 7'd0;
      r_count <= 2'd0;
    end else if (load) begin
      r_value <= load_val;
      r_count <= load_cnt;
    end else if (clr) begin
      r_value <= 7'd0;
      r_count <= 2'd0;
    end else if (push && (r_count != DIGITS_MAX)) begin
      // At most two digits, so the result never exceeds 99 and fits 7 bits
      r_value <= r_value * 7'd10 + {3'b000, digit};
      r_count <= r_count + 2'd1;
    end else if (bksp && (r_count != 2'd0)) begin
      r_value <= r_value / 7'd10;
      r_count <= r_count - 2'd1;
    end
  end

  assign value = r_value;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Keypad-driven controller for the calculator datapath. Builds
//                two-digit operands A and B from key events, selects the
//                operation, launches the external ALU with a start/done
//                handshake, latches the result and supports chaining/clear.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                ativo, key_valid, key_code - keypad interface
//                op_a, op_b, op_sel, alu_start - ALU launch
//                alu_done, alu_result, alu_neg - ALU completion
//                result, result_neg, result_valid - held result for display
//                busy, err               - status
//  Options     : CALC_BACKSPACE_EN - when defined, key D deletes the last
//                digit of the operand being entered (S_A / S_B).
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
  parameter int RES_W   = 14,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ativo,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic [6:0]       op_a,
  output logic [6:0]       op_b,
  output logic [1:0]       op_sel,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_neg,
  output logic [RES_W-1:0] result,
  output logic             result_neg,
  output logic             result_valid,
  output logic             busy,
  output logic             err
);
  import calc_pkg::*;

`ifdef CALC_BACKSPACE_EN
  localparam logic c_bksp_en = 1'b1;
`else
  localparam logic c_bksp_en = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_tcnt;
  logic [1:0]       r_op_sel;
  logic [RES_W-1:0] r_result;
  logic             r_result_neg;
  logic             r_result_valid;

  // Key decode
  logic       w_key_ok;
  logic       w_digit_key;
  logic       w_op_key;
  logic       w_star;
  logic       w_hash;
  logic       w_bksp_key;
  logic [3:0] w_digit;
  logic       w_chain_ok;
  logic       w_timeout;

  // Datapath control strobes
  logic       w_full_clr;
  logic       w_a_load;
  logic [6:0] w_a_load_val;
  logic [1:0] w_a_load_cnt;
  logic       w_a_push;
  logic       w_a_bksp;
  logic       w_b_clr;
  logic       w_b_push;
  logic       w_b_bksp;
  logic       w_sel_we;
  logic [1:0] w_sel_val;
  logic       w_res_latch;

  logic [1:0] w_cnt_a;
  logic [1:0] w_cnt_b;

  assign w_key_ok    = key_valid & ativo;
  assign w_digit_key = is_digit(key_code);
  assign w_op_key    = is_op(key_code);
  assign w_star      = (key_code == T_ASTE);
  assign w_hash      = (key_code == T_HASH);
  assign w_bksp_key  = c_bksp_en & (key_code == T_D);
  assign w_digit     = key_code[3:0];

  // A held result can seed operand A only if it is a non-negative 2-digit value
  assign w_chain_ok = !r_result_neg && (r_result <= RES_W'(MAX_OPERAND));

  // Counter holds c on cycle c of S_EXEC, so leaving on TIMEOUT-1 puts err
  // high exactly TIMEOUT cycles after the alu_start cycle.
  assign w_timeout = (r_tcnt == CNT_W'(TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_A: begin
        if (w_key_ok && w_op_key) w_next_state = S_B;
      end
      S_B: begin
        if (w_key_ok && w_star)                          w_next_state = S_A;
        else if (w_key_ok && w_hash && (w_cnt_b != 2'd0)) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        // Abort beats a coincident alu_done; done beats the timeout
        if (w_key_ok && w_star) w_next_state = S_A;
        else if (alu_done)      w_next_state = S_SHOW;
        else if (w_timeout)     w_next_state = S_ERR;
      end
      S_SHOW: begin
        if (w_key_ok) begin
          if (w_digit_key || w_star) w_next_state = S_A;
          else if (w_op_key)         w_next_state = w_chain_ok ? S_B : S_ERR;
        end
      end
      S_ERR: begin
        if (w_key_ok && w_star) w_next_state = S_A;
      end
      default: w_next_state = S_A;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_full_clr   = 1'b0;
    w_a_load     = 1'b0;
    w_a_load_val = 7'd0;
    w_a_load_cnt = 2'd0;
    w_a_push     = 1'b0;
    w_a_bksp     = 1'b0;
    w_b_clr      = 1'b0;
    w_b_push     = 1'b0;
    w_b_bksp     = 1'b0;
    w_sel_we     = 1'b0;
    w_sel_val    = OP_SUM;
    w_res_latch  = 1'b0;
    alu_start    = 1'b0;
    busy         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_A: begin
        if (w_key_ok) begin
          if (w_digit_key) begin
            w_a_push = (w_cnt_a != DIGITS_MAX);
          end else if (w_op_key) begin
            w_sel_we  = 1'b1;
            w_sel_val = key_to_op(key_code);
            w_b_clr   = 1'b1;
          end else if (w_star) begin
            w_full_clr = 1'b1;
          end else if (w_bksp_key) begin
            w_a_bksp = 1'b1;
          end
        end
      end
      S_B: begin
        if (w_key_ok) begin
          if (w_digit_key) begin
            w_b_push = (w_cnt_b != DIGITS_MAX);
          end else if (w_op_key) begin
            w_sel_we  = 1'b1;
            w_sel_val = key_to_op(key_code);
          end else if (w_star) begin
            w_full_clr = 1'b1;
          end else if (w_bksp_key) begin
            w_b_bksp = 1'b1;
          end
        end
      end
      S_EXEC: begin
        busy      = 1'b1;
        alu_start = (r_tcnt == '0);
        if (w_key_ok && w_star) w_full_clr  = 1'b1;
        else if (alu_done)      w_res_latch = 1'b1;
      end
      S_SHOW: begin
        if (w_key_ok) begin
          if (w_digit_key) begin
            // New calculation: clear everything, the digit becomes A
            w_full_clr   = 1'b1;
            w_a_load     = 1'b1;
            w_a_load_val = {3'b000, w_digit};
            w_a_load_cnt = 2'd1;
          end else if (w_op_key && w_chain_ok) begin
            // Chaining: previous result becomes a complete operand A
            w_a_load     = 1'b1;
            w_a_load_val = r_result[6:0];
            w_a_load_cnt = DIGITS_MAX;
            w_sel_we     = 1'b1;
            w_sel_val    = key_to_op(key_code);
            w_b_clr      = 1'b1;
          end else if (w_star) begin
            w_full_clr = 1'b1;
          end
        end
      end
      S_ERR: begin
        err = 1'b1;
        if (w_key_ok && w_star) w_full_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (r_state == S_EXEC) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end else begin
      r_tcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_sel <= OP_SUM;
    end else if (w_full_clr) begin
      r_op_sel <= OP_SUM;
    end else if (w_sel_we) begin
      r_op_sel <= w_sel_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result       <= '0;
      r_result_neg   <= 1'b0;
      r_result_valid <= 1'b0;
    end else if (w_res_latch) begin
      r_result       <= alu_result;
      r_result_neg   <= alu_neg;
      r_result_valid <= 1'b1;
    end else if (w_full_clr) begin
      r_result_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Operand accumulators
  // --------------------------------------------------------------------------
  digit_accum u_acc_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_full_clr),
    .load     (w_a_load),
    .load_val (w_a_load_val),
    .load_cnt (w_a_load_cnt),
    .push     (w_a_push),
    .digit    (w_digit),
    .bksp     (w_a_bksp),
    .value    (op_a),
    .count    (w_cnt_a)
  );

  digit_accum u_acc_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_full_clr | w_b_clr),
    .load     (1'b0),
    .load_val (7'd0),
    .load_cnt (2'd0),
    .push     (w_b_push),
    .digit    (w_digit),
    .bksp     (w_b_bksp),
    .value    (op_b),
    .count    (w_cnt_b)
  );

  assign op_sel       = r_op_sel;
  assign result       = r_result;
  assign result_neg   = r_result_neg;
  assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_sequencer
//  Description : Self-checking bench for calc_sequencer. A reference model
//                tracks operands as digit lists; expected ALU launches and
//                execution outcomes go into queues consumed by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;
  localparam int RES_W   = 14;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  localparam int K_D = 13, K_STAR = 14, K_HASH = 15;
  localparam int M_A = 0, M_B = 1, M_SHOW = 2, M_ERR = 3;
  localparam int O_RES = 0, O_ERR = 1, O_ABORT = 2, O_RESET = 3;

`ifdef CALC_BACKSPACE_EN
  localparam bit BKSP = 1'b1;
`else
  localparam bit BKSP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ativo = 1'b1;
  logic             key_valid = 1'b0;
  logic [4:0]       key_code = 5'd0;
  logic [6:0]       op_a, op_b;
  logic [1:0]       op_sel;
  logic             alu_start;
  logic             alu_done = 1'b0;
  logic [RES_W-1:0] alu_result = '0;
  logic             alu_neg = 1'b0;
  logic [RES_W-1:0] result;
  logic             result_neg, result_valid, busy, err;

  always #5 clk = ~clk;

  calc_sequencer #(.RES_W(RES_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ativo(ativo), .key_valid(key_valid),
    .key_code(key_code), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .alu_neg(alu_neg), .result(result), .result_neg(result_neg),
    .result_valid(result_valid), .busy(busy), .err(err)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int mode = M_A;
  int adig[$];
  int bdig[$];
  int sel = 0, res = 0, neg = 0, rv = 0;

  typedef struct { int a; int b; int sel; } launch_t;
  typedef struct { int kind; int res; int neg; } outc_t;
  launch_t launch_q[$];
  outc_t   out_q[$];

  int alu_lat = -1;
  bit alu_active = 1'b0;

  function automatic int qval(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  task automatic clear_all();
    adig.delete(); bdig.delete();
    sel = 0; rv = 0; mode = M_A;
  endtask

  task automatic model_apply(input int k);
    case (mode)
      M_A, M_B: begin
        if (k <= 9) begin
          if (mode == M_A && adig.size() < 2) adig.push_back(k);
          if (mode == M_B && bdig.size() < 2) bdig.push_back(k);
        end else if (k >= 10 && k <= 12) begin
          sel = k - 10;
          if (mode == M_A) begin bdig.delete(); mode = M_B; end
        end else if (k == K_D && BKSP) begin
          if (mode == M_A && adig.size() > 0) void'(adig.pop_back());
          if (mode == M_B && bdig.size() > 0) void'(bdig.pop_back());
        end else if (k == K_STAR) clear_all();
      end
      M_SHOW: begin
        if (k <= 9) begin
          clear_all(); adig.push_back(k);
        end else if (k >= 10 && k <= 12) begin
          if (neg == 0 && res <= 99) begin
            adig.delete();
            if (res >= 10) adig.push_back(res / 10);
            adig.push_back(res % 10);
            sel = k - 10; bdig.delete(); mode = M_B;
          end else mode = M_ERR;
        end else if (k == K_STAR) clear_all();
      end
      default: if (k == K_STAR) clear_all();
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_op_a"}, int'(op_a), qval(adig));
    chk({tag, "_op_b"}, int'(op_b), qval(bdig));
    chk({tag, "_op_sel"}, int'(op_sel), sel);
    chk({tag, "_err"}, int'(err), (mode == M_ERR) ? 1 : 0);
    chk({tag, "_result_valid"}, int'(result_valid), rv);
    chk({tag, "_busy"}, int'(busy), 0);
    if (rv == 1) chk({tag, "_result"}, int'(result), res);
  endtask

  // ---------------- ALU responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
        int a, b, s, lat;
        alu_active = 1'b1;
        a = int'(op_a); b = int'(op_b); s = int'(op_sel); lat = alu_lat;
        case (s)
          1:       begin alu_result = RES_W'((a >= b) ? a - b : b - a); alu_neg = (a < b); end
          2:       begin alu_result = RES_W'(a * b); alu_neg = 1'b0; end
          default: begin alu_result = RES_W'(a + b); alu_neg = 1'b0; end
        endcase
        if (lat >= 0) begin
          repeat (lat) @(posedge clk);
          #1 alu_done = 1'b1;
          @(posedge clk);
          #1 alu_done = 1'b0;
        end
        alu_active = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_busy;
    int start_cyc;
    prev_busy = 1'b0;
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
        if (launch_q.size() == 0) chk("unexpected_alu_start", 1, 0);
        else begin
          launch_t l;
          l = launch_q.pop_front();
          chk("launch_op_a", int'(op_a), l.a);
          chk("launch_op_b", int'(op_b), l.b);
          chk("launch_op_sel", int'(op_sel), l.sel);
        end
        start_cyc = cyc;
      end
      if (prev_busy && busy !== 1'b1) begin
        if (out_q.size() == 0) chk("unexpected_exec_end", 1, 0);
        else begin
          outc_t o;
          o = out_q.pop_front();
          case (o.kind)
            O_RES: begin
              chk("exec_result", int'(result), o.res);
              chk("exec_result_neg", int'(result_neg), o.neg);
              chk("exec_result_valid", int'(result_valid), 1);
              chk("exec_err", int'(err), 0);
            end
            O_ERR: begin
              chk("timeout_err", int'(err), 1);
              chk("timeout_cycles", cyc - start_cyc, TIMEOUT);
            end
            default: begin
              chk("cleared_result_valid", int'(result_valid), 0);
              chk("cleared_op_a", int'(op_a), 0);
              chk("cleared_op_b", int'(op_b), 0);
              chk("cleared_err", int'(err), 0);
            end
          endcase
        end
      end
      prev_busy = (busy === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic press_raw(input int k, input int av);
    key_code  = 5'(k);
    key_valid = 1'b1;
    ativo     = av[0];
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    ativo     = 1'b1;
    key_code  = 5'd0;
  endtask

  task automatic exec_run(input int lat, input int abort_at);
    int a, b, r, n, kind, k;
    launch_t l;
    outc_t o;
    a = qval(adig); b = qval(bdig);
    case (sel)
      1:       begin r = (a >= b) ? a - b : b - a; n = (a < b) ? 1 : 0; end
      2:       begin r = a * b; n = 0; end
      default: begin r = a + b; n = 0; end
    endcase
    kind = (abort_at >= 0) ? O_ABORT : ((lat < 0) ? O_ERR : O_RES);
    l.a = a; l.b = b; l.sel = sel;
    o.kind = kind; o.res = r; o.neg = n;
    launch_q.push_back(l);
    out_q.push_back(o);
    alu_lat = lat;
    press_raw(K_HASH, 1);
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      if (busy !== 1'b1) break;
      if (i == abort_at) press_raw(K_STAR, 1);
      else if ($urandom_range(0, 2) == 0) begin
        k = K_STAR;
        while (k == K_STAR) k = int'($urandom_range(0, 31));
        press_raw(k, int'($urandom_range(0, 1)));
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("exec_finished", int'(busy), 0);
    case (kind)
      O_RES:   begin mode = M_SHOW; res = r; neg = n; rv = 1; end
      O_ERR:   mode = M_ERR;
      default: clear_all();
    endcase
    for (int i = 0; i < 40 && alu_active; i++) begin
      @(posedge clk);
      #1;
    end
    check_state("post_exec");
  endtask

  task automatic key(input int k, input int av = 1, input int lat = -2, input int ab = -1);
    int r;
    if (av != 0 && mode == M_B && k == K_HASH && bdig.size() > 0) begin
      if (lat == -2) begin
        r = int'($urandom_range(0, 9));
        ab = -1;
        if (r < 7) lat = int'($urandom_range(0, 20));
        else if (r == 7) lat = -1;
        else begin
          lat = int'($urandom_range(0, 12));
          ab  = int'($urandom_range(0, lat));
        end
      end
      exec_run(lat, ab);
    end else begin
      press_raw(k, av);
      if (av != 0) model_apply(k);
      check_state("key");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, av;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_a", int'(op_a), 0);
    chk("rst_op_b", int'(op_b), 0);
    chk("rst_op_sel", int'(op_sel), 0);
    chk("rst_alu_start", int'(alu_start), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_neg", int'(result_neg), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 42 + 7 with a 3-cycle ALU
    key(4); key(2); key(10); key(7); key(K_HASH, 1, 3, -1);
    chk("tp1_result", int'(result), 49);
    chk("tp1_result_valid", int'(result_valid), 1);
    key(K_STAR);

    // Third digit ignored, '#' with empty B ignored
    key(1); key(2); key(3);
    chk("tp2_op_a", int'(op_a), 12);
    key(11); key(K_HASH);
    chk("tp2_no_exec", int'(busy), 0);
    key(K_STAR);

    // Key ignored while ativo=0
    key(5, 0);
    chk("ativo_block", int'(op_a), 0);

    // Chain from 20, then 100 cannot chain
    key(1); key(5); key(10); key(5); key(K_HASH, 1, 2, -1);
    key(12); key(5); key(K_HASH, 1, 5, -1);
    chk("chain_result", int'(result), 100);
    key(10);
    chk("chain_err", int'(err), 1);
    key(K_STAR);
    key(1); key(5); key(12); key(1); key(0); key(K_HASH, 1, 0, -1);
    key(10);
    chk("chain150_err", int'(err), 1);
    key(K_STAR);

    // Timeout, then abort on the same edge as alu_done
    key(9); key(11); key(9); key(K_HASH, 1, -1, -1);
    key(K_STAR);
    key(2); key(10); key(3); key(K_HASH, 1, 4, 4);

    // Backspace
    key(4); key(7); key(K_D);
    chk("bksp_op_a", int'(op_a), BKSP ? 4 : 47);
    key(K_STAR);

    // Reset in the middle of S_EXEC; the late alu_done must be ignored
    begin
      launch_t l;
      outc_t o;
      key(3); key(10); key(4);
      l.a = 3; l.b = 4; l.sel = 0;
      o.kind = O_RESET; o.res = 0; o.neg = 0;
      launch_q.push_back(l);
      out_q.push_back(o);
      alu_lat = 10;
      press_raw(K_HASH, 1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_op_a", int'(op_a), 0);
      chk("midrst_op_b", int'(op_b), 0);
      chk("midrst_alu_start", int'(alu_start), 0);
      chk("midrst_result_valid", int'(result_valid), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_all();
      res = 0; neg = 0;
      repeat (15) @(posedge clk);
      #1;
      check_state("after_midrst");
      chk("after_midrst_result", int'(result), 0);
    end

    // Randomized key streams
    for (int i = 0; i < 250; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 45)      k = int'($urandom_range(0, 9));
      else if (k < 60) k = int'($urandom_range(10, 12));
      else if (k < 66) k = K_D;
      else if (k < 74) k = K_STAR;
      else if (k < 92) k = K_HASH;
      else             k = int'($urandom_range(16, 31));
      av = ($urandom_range(0, 9) != 0) ? 1 : 0;
      key(k, av);
    end

    chk("launch_q_drained", launch_q.size(), 0);
    chk("out_q_drained", out_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Keypad-driven controller for the calculator arithmetic datapath.
- Accepts one-cycle key events from the keypad scanner and builds two-digit decimal operands A and B (0..99).
- Selects the operation, launches the external ALU with a start/done handshake, latches and holds the result, and supports chaining and clear.
- Sits between the keypad scanner and the ALU; the display driver reads result/result_neg/result_valid.

Parameters:
- RES_W, 14, result width in bits (99*99 = 9801 fits).
- TIMEOUT, 64, max cycles from alu_start to alu_done before error.
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ativo  in  1  key-input enable; when 0, key events are ignored
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  5  0-9 digits, 10 A=SUM, 11 B=SUB, 12 C=MUL, 13 D, 14 '*'=CLEAR, 15 '#'=EQUALS; others ignored
- op_a  out  7  operand A to ALU
- op_b  out  7  operand B to ALU
- op_sel  out  2  0 SUM, 1 SUB, 2 MUL
- alu_start  out  1  one-cycle launch pulse
- alu_done  in  1  ALU completion strobe
- alu_result  in  RES_W  ALU magnitude
- alu_neg  in  1  ALU sign (SUB with A<B)
- result  out  RES_W  latched magnitude
- result_neg  out  1  latched sign
- result_valid  out  1  result held and valid
- busy  out  1  high in S_EXEC
- err  out  1  high in S_ERR

Behaviour:
- Reset (async, rst_n=0): state S_A; op_a=0, op_b=0, op_sel=SUM, digit counts=0, alu_start=0, result=0, result_neg=0, result_valid=0, busy=0, err=0.
- A key is accepted on a rising edge with key_valid & ativo. Register updates are visible the next cycle. Unaccepted keys have no effect.
- Digit entry: operand <= operand*10 + d, computed at 7 bits (max 99). The per-operand digit count saturates at 2; a third digit is ignored.
- S_A:
  - digit -> accumulate into op_a.
  - A/B/C -> set op_sel, clear op_b and its count, go to S_B.
  - '#' -> ignored.
  - '*' -> clear operands and counts, op_sel=SUM, stay in S_A.
- S_B:
  - digit -> accumulate into op_b.
  - A/B/C -> update op_sel, stay in S_B.
  - '#' with B count=0 -> ignored.
  - '#' with B count>0 -> go to S_EXEC.
  - '*' -> full clear, go to S_A.
- S_EXEC:
  - alu_start=1 for exactly the first cycle in the state. busy=1 throughout.
  - op_a, op_b and op_sel are held stable.
  - Digits and operator keys are ignored.
  - '*' aborts: no latch, full clear, go to S_A.
  - alu_done -> latch result<=alu_result, result_neg<=alu_neg, result_valid<=1, go to S_SHOW.
  - If alu_done arrives on the same edge as an accepted '*', the abort wins.
  - The timeout counter starts at 0 on entry and increments each cycle. When it reaches TIMEOUT without alu_done -> go to S_ERR.
- S_SHOW:
  - digit d -> clear, op_a=d, count=1, result_valid=0, go to S_A.
  - A/B/C (chaining):
    - if result_neg=0 and result<=99: op_a<=result, op_sel set, op_b cleared, go to S_B; result_valid stays 1 until the next result.
    - otherwise go to S_ERR.
  - '#' -> ignored.
  - '*' -> full clear, result_valid=0, go to S_A.
- S_ERR: err=1. Only '*' exits (full clear, result_valid=0, go to S_A).
- alu_done outside S_EXEC is ignored.
- ativo=0 only blocks keys; the S_EXEC wait and timeout continue.

Optional Feature:
- Macro CALC_BACKSPACE_EN.
- Defined: key D in S_A or S_B deletes the last digit (operand <= operand/10, count-1, no-op at count 0).
- Undefined: key D is ignored in all states.

Decomposition:
- Package calc_pkg holds:
  - key code constants (T_0..T_9, T_A, T_B, T_C, T_D, T_ASTE, T_HASH)
  - op codes OP_SUM/OP_SUB/OP_MUL
  - state enum S_A/S_B/S_EXEC/S_SHOW/S_ERR
- Sub-module digit_accum holds the 7-bit value, 2-bit count, load, clear and optional backspace. It is instantiated twice (A, B).

Test Plan:
- Keys 4,2,A,7,# with ALU done 3 cycles after start returning 49 -> op_a=42, op_b=7, op_sel=0, exactly one alu_start, result=49, result_valid=1.
- Keys 1,2,3 -> op_a=12 (third digit ignored); then B,# -> stays in S_B, no alu_start.
- From result 20: keys C,5,# -> op_a=20, op_sel=2, op_b=5. From result 150: key A -> err=1; then '*' -> S_A, all cleared.
- S_EXEC with alu_done never asserted -> err=1 exactly TIMEOUT cycles after alu_start, busy=0.
- rst_n low mid S_EXEC -> all outputs to reset values immediately; late alu_done is ignored.
- With CALC_BACKSPACE_EN: keys 4,7,D -> op_a=4. Without the macro: op_a=47.
